// File: rtl/imem_loader_8085_if.sv
// Byte-stream handshake and instruction-memory write bus shared by the host
// byte source (master) and the instruction-memory loader (slave).
interface imem_loader_8085_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader_8085.sv
// Loads a framed byte stream (length, program, checksum) into the 8085 instruction
// memory and releases the processor only after the checksum verifies.
module imem_loader_8085 #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_loader_8085_if.slave     bus,
    input  logic                  reload,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  err
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] S_WAIT_LEN = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_FAIL     = 3'd4;

    function automatic logic len_ok(input logic [DATA_W-1:0] n);
        return (n != '0) && (int'(n) <= DEPTH);
    endfunction

    function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    logic [2:0]        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nx;
    logic [DATA_W-1:0] sum;
    logic              ready_state;
    logic              xfer;
    logic              we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;

    // Ready is withheld while reload is pending so an aborted byte is never acknowledged.
    assign ready_state  = (state == S_WAIT_LEN) || (state == S_LOAD) || (state == S_CHECK);
    assign bus.in_ready = ready_state && !rst && !reload;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign count_nx     = count + 1'b1;

    // Write stage: an accepted program byte appears on the memory bus one cycle later.
    assign bus.mem_we    = we_p1 && !rst;
    assign bus.mem_addr  = addr_p1;
    assign bus.mem_wdata = wdata_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT_LEN;
            len       <= '0;
            count     <= '0;
            sum       <= '0;
            we_p1     <= 1'b0;
            addr_p1   <= '0;
            wdata_p1  <= '0;
            load_done <= 1'b0;
            cpu_run   <= 1'b0;
            err       <= 1'b0;
        end else begin
            we_p1     <= 1'b0;
            load_done <= 1'b0;
            if (reload) begin
                state   <= S_WAIT_LEN;
                count   <= '0;
                sum     <= '0;
                err     <= 1'b0;
                cpu_run <= 1'b0;
            end else begin
                case (state)
                    S_WAIT_LEN: begin
                        if (xfer) begin
                            if (len_ok(bus.in_data)) begin
                                len   <= bus.in_data[ADDR_W:0];
                                count <= '0;
                                sum   <= '0;
                                state <= S_LOAD;
                            end else begin
                                state <= S_FAIL;
                                err   <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (xfer) begin
                            we_p1    <= 1'b1;
                            addr_p1  <= count[ADDR_W-1:0];
                            wdata_p1 <= bus.in_data;
                            count    <= count_nx;
                            sum      <= sum_add(sum, bus.in_data);
                            if (count_nx == len) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (xfer) begin
                            if (bus.in_data == sum) begin
                                state     <= S_RUN;
                                load_done <= 1'b1;
                            end else begin
                                state <= S_FAIL;
                                err   <= 1'b1;
                            end
                        end
                    end
                    // cpu_run rises the cycle after load_done, behind the final write.
                    S_RUN: begin
                        cpu_run <= 1'b1;
                    end
                    S_FAIL: begin
                        cpu_run <= 1'b0;
                    end
                    default: begin
                        state <= S_WAIT_LEN;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader_8085.sv
// Directed bench for imem_loader_8085: table of whole frames plus hand-written
// sequences for reset mid-load, reload mid-load, ignored input and a full 32-word load.
module tb_imem_loader_8085;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic reload = 1'b0;
    logic cpu_run, load_done, err;

    imem_loader_8085_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    imem_loader_8085 #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .reload    (reload),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       n;
        logic [3:0][7:0]  d;
        logic [7:0]       c;
        logic             pass;
        logic [5:0]       writes;
        logic             gap;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [7:0] shadow [32];
    bit         written [32];
    int         wr_cnt, dup_cnt, ld_cnt, last_addr, cyc, ld_cyc, run_rise;
    logic       run_prev;

    // Bus monitor: samples registered outputs mid-cycle.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (bus.mem_we) begin
            wr_cnt++;
            if (written[bus.mem_addr]) dup_cnt++;
            written[bus.mem_addr] = 1'b1;
            shadow[bus.mem_addr]  = bus.mem_wdata;
            last_addr = int'(bus.mem_addr);
        end
        if (load_done) begin
            ld_cnt++;
            ld_cyc = cyc;
        end
        if (cpu_run && !run_prev) run_rise = cyc;
        run_prev = cpu_run;
    end

    task automatic clr_mon();
        wr_cnt = 0; dup_cnt = 0; ld_cnt = 0; last_addr = -1;
        ld_cyc = -100; run_rise = -1;
        for (int i = 0; i < 32; i++) written[i] = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            #1;
            if (bus.in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        #1;
        check({tag, "_reload_cpu_run"}, cpu_run, 0);
        check({tag, "_reload_err"}, err, 0);
        check({tag, "_reload_in_ready"}, bus.in_ready, 1);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        bit ok;
        int mism;
        clr_mon();
        send_byte(v.n, ok);
        check($sformatf("v%0d_len_hs", idx), ok, 1);
        if (v.n != 8'd0 && int'(v.n) <= 32) begin
            for (int i = 0; i < int'(v.n); i++) begin
                send_byte(v.d[i], ok);
                check($sformatf("v%0d_byte%0d_hs", idx, i), ok, 1);
                if (v.gap) idle(1);
            end
            send_byte(v.c, ok);
            check($sformatf("v%0d_sum_hs", idx), ok, 1);
        end
        idle(3);
        #3;
        check($sformatf("v%0d_err", idx), err, v.pass ? 0 : 1);
        check($sformatf("v%0d_cpu_run", idx), cpu_run, v.pass ? 1 : 0);
        check($sformatf("v%0d_in_ready", idx), bus.in_ready, 0);
        check($sformatf("v%0d_load_done_cnt", idx), ld_cnt, v.pass ? 1 : 0);
        check($sformatf("v%0d_writes", idx), wr_cnt, int'(v.writes));
        check($sformatf("v%0d_dups", idx), dup_cnt, 0);
        mism = 0;
        for (int i = 0; i < int'(v.writes); i++)
            if (!written[i] || shadow[i] !== v.d[i]) mism++;
        check($sformatf("v%0d_mem_data", idx), mism, 0);
        if (v.pass) check($sformatf("v%0d_run_after_done", idx), run_rise - ld_cyc, 1);
    endtask

    function automatic vec_t mk(input int n, input int d0, input int d1, input int d2,
                                input int d3, input int c, input int pass,
                                input int writes, input int gap);
        vec_t v;
        v.n      = 8'(n);
        v.d[0]   = 8'(d0);
        v.d[1]   = 8'(d1);
        v.d[2]   = 8'(d2);
        v.d[3]   = 8'(d3);
        v.c      = 8'(c);
        v.pass   = 1'(pass);
        v.writes = 6'(writes);
        v.gap    = 1'(gap);
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        bit   ok;
        int   mism;

        vecs[0] = mk(3, 'h3E, 'h05, 'h80, 'h00, 'hC3, 1, 3, 0);
        vecs[1] = mk(3, 'h3E, 'h05, 'h80, 'h00, 'hC4, 0, 3, 0);
        vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(33, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(1, 'hFF, 0, 0, 0, 'hFF, 1, 1, 0);
        vecs[5] = mk(2, 'hFF, 'h02, 0, 0, 'h01, 1, 2, 0);
        vecs[6] = mk(4, 'h10, 'h20, 'h30, 'h40, 'hA0, 1, 4, 1);
        vecs[7] = mk(4, 'h01, 'h02, 'h03, 'h04, 'h0B, 0, 4, 1);

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        run_prev     = 1'b0;
        cyc          = 0;
        clr_mon();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready_low", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready_high", bus.in_ready, 1);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_mem_wdata", int'(bus.mem_wdata), 0);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_load_done", load_done, 0);
        check("rst_err", err, 0);

        // Frame table; every frame ends in RUN or FAIL and is released by reload
        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k], k);
            do_reload($sformatf("v%0d", k));
        end

        // Full-depth frame: 0x01..0x20, checksum 528 mod 256
        clr_mon();
        send_byte(8'd32, ok);
        check("full_len_hs", ok, 1);
        for (int i = 1; i <= 32; i++) begin
            send_byte(8'(i), ok);
            if (!ok) check("full_byte_hs", ok, 1);
        end
        send_byte(8'h10, ok);
        check("full_sum_hs", ok, 1);
        idle(3);
        #3;
        check("full_writes", wr_cnt, 32);
        check("full_last_addr", last_addr, 31);
        check("full_cpu_run", cpu_run, 1);
        check("full_err", err, 0);
        mism = 0;
        for (int i = 0; i < 32; i++) if (shadow[i] !== 8'(i + 1)) mism++;
        check("full_mem_data", mism, 0);

        // Input offered in RUN is ignored
        clr_mon();
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h55;
        end
        idle(2);
        #3;
        check("run_ignore_writes", wr_cnt, 0);
        check("run_ignore_cpu_run", cpu_run, 1);
        do_reload("full");

        // Reload mid-load discards partial sum; next byte is a fresh length
        clr_mon();
        send_byte(8'd3, ok);
        send_byte(8'hAA, ok);
        do_reload("midload");
        send_byte(8'd1, ok);
        send_byte(8'h07, ok);
        send_byte(8'h07, ok);
        check("midload_sum_hs", ok, 1);
        idle(3);
        #3;
        check("midload_cpu_run", cpu_run, 1);
        check("midload_err", err, 0);
        check("midload_writes", wr_cnt, 2);
        do_reload("midload2");

        // rst after the 2nd byte of a toggled N=4 load suppresses the pending write
        clr_mon();
        send_byte(8'd4, ok);
        idle(1);
        send_byte(8'h11, ok);
        idle(1);
        send_byte(8'h22, ok);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #3;
        check("rstmid_mem_we", bus.mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("rstmid_cpu_run", cpu_run, 0);
        check("rstmid_err", err, 0);
        check("rstmid_in_ready", bus.in_ready, 1);
        check("rstmid_writes", wr_cnt, 1);
        check("rstmid_addr0", int'(shadow[0]), 'h11);
        send_byte(8'h00, ok);
        check("rstmid_len_hs", ok, 1);
        idle(2);
        #3;
        check("rstmid_len_fail_err", err, 1);
        check("rstmid_len_fail_writes", wr_cnt, 1);

        // Input offered in FAIL is ignored
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h02;
        end
        idle(2);
        #3;
        check("fail_ignore_err", err, 1);
        check("fail_ignore_writes", wr_cnt, 1);
        do_reload("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
